// File: rtl/led_sched_pkg.sv
// Shared state encoding, LED pattern constants and small decode helpers
// for the LED pattern scheduler.
package led_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    TOG  = 3'd4
  } state_t;

  localparam logic [7:0] PAT_OFF = 8'h00;
  localparam logic [7:0] PAT_ONE = 8'h01;
  localparam logic [7:0] PAT_MSB = 8'h80;
  localparam logic [7:0] PAT_A   = 8'h55;
  localparam logic [7:0] PAT_B   = 8'hAA;

  // Fixed priority: the highest-numbered active switch selects the mode.
  function automatic state_t decode_req(input logic [3:0] sw);
    state_t s;
    if (sw[3])      s = TOG;
    else if (sw[2]) s = SHR;
    else if (sw[1]) s = SHL;
    else if (sw[0]) s = HOLD;
    else            s = IDLE;
    return s;
  endfunction

  function automatic state_t next_auto(input state_t s);
    state_t n;
    case (s)
      HOLD:    n = SHL;
      SHL:     n = SHR;
      SHR:     n = TOG;
      default: n = HOLD;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] entry_led(input state_t s);
    logic [7:0] v;
    case (s)
      HOLD:    v = PAT_ONE;
      SHL:     v = PAT_ONE;
      SHR:     v = PAT_MSB;
      TOG:     v = PAT_A;
      default: v = PAT_OFF;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-clk tick every TICK_DIV clocks, asserted on
// the last count of each period.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 24'hA00000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign tick     = (cnt_reg == CNT_LAST);
  assign cnt_next = tick ? '0 : cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

endmodule

// File: rtl/led_pattern_sched.sv
// LED pattern scheduler: synchronises and debounces the mode switches,
// then steps the pattern FSM and LED register once per slow tick.
module led_pattern_sched
  import led_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV = 24'hA00000,
  parameter int unsigned DEB_CYC  = 16,
  parameter int unsigned TOG_HALF = 8,
  parameter int unsigned DWELL    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] SW,
  input  logic       auto_en,
  output logic [7:0] LED,
  output logic [2:0] mode,
  output logic       tick
);

  localparam int DB_W  = $clog2(DEB_CYC + 1);
  localparam int TOG_W = $clog2(2 * TOG_HALF);
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEB_CYC);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * TOG_HALF - 1);
  localparam logic [TOG_W-1:0] TOG_MID  = TOG_W'(TOG_HALF);
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  logic [3:0] sw_sync;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic [1:0] sync_pipe_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_pipe_reg <= 2'b00;
        else        sync_pipe_reg <= {sync_pipe_reg[0], SW[gi]};
      end
      assign sw_sync[gi] = sync_pipe_reg[1];
    end
  endgenerate

  // Debounce: db_cnt counts consecutive identical synced samples (saturating);
  // sw_db follows only once a run reaches DEB_CYC.
  logic [3:0]      cand_reg, sw_db_reg, sw_db_next;
  logic [DB_W-1:0] db_cnt_reg, db_cnt_next;

  always_comb begin
    db_cnt_next = DB_W'(1);
    if (sw_sync == cand_reg)
      db_cnt_next = (db_cnt_reg == DB_MAX) ? DB_MAX : db_cnt_reg + 1'b1;
    sw_db_next = (db_cnt_next == DB_MAX) ? sw_sync : sw_db_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg   <= 4'b0000;
      sw_db_reg  <= 4'b0000;
      db_cnt_reg <= '0;
    end else begin
      cand_reg   <= sw_sync;
      sw_db_reg  <= sw_db_next;
      db_cnt_reg <= db_cnt_next;
    end
  end

  state_t           state_reg, state_next, req, target;
  logic [7:0]       led_reg, led_next;
  logic [TOG_W-1:0] tog_reg, tog_next, tog_inc;
  logic [DW_W-1:0]  dwell_reg, dwell_next;
  logic             enter, animate;

  assign req = decode_req(sw_db_reg);

  always_comb begin
    state_next = state_reg;
    led_next   = led_reg;
    tog_next   = tog_reg;
    dwell_next = dwell_reg;
    enter      = 1'b0;
    animate    = 1'b0;
    target     = state_reg;
    tog_inc    = (tog_reg == TOG_LAST) ? '0 : tog_reg + 1'b1;

    if (tick) begin
      if (!auto_en) begin
        if (req != state_reg) begin
          enter  = 1'b1;
          target = req;
        end else begin
          animate = 1'b1;
        end
      end else if (state_reg == IDLE) begin
        enter  = 1'b1;
        target = HOLD;
      end else if (dwell_reg == DW_LAST) begin
        enter  = 1'b1;
        target = next_auto(state_reg);
      end else begin
        animate    = 1'b1;
        dwell_next = dwell_reg + 1'b1;
      end
    end

    if (enter) begin
      state_next = target;
      led_next   = entry_led(target);
      tog_next   = '0;
      dwell_next = '0;
    end else if (animate) begin
      case (state_reg)
        SHL: led_next = {led_reg[6:0], led_reg[7]};
        SHR: led_next = {led_reg[0], led_reg[7:1]};
        TOG: begin
          tog_next = tog_inc;
          led_next = (tog_inc < TOG_MID) ? PAT_A : PAT_B;
        end
        default: led_next = led_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      led_reg   <= PAT_OFF;
      tog_reg   <= '0;
      dwell_reg <= '0;
    end else begin
      state_reg <= state_next;
      led_reg   <= led_next;
      tog_reg   <= tog_next;
      dwell_reg <= dwell_next;
    end
  end

  assign LED  = led_reg;
  assign mode = state_reg;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Randomised scoreboard bench for led_pattern_sched: a rule-level model
// predicts LED/mode for every tick, a monitor compares on each DUT tick.
module tb_led_pattern_sched;

  localparam int TICK_DIV = 4;
  localparam int DEB_CYC  = 2;
  localparam int TOG_HALF = 2;
  localparam int DWELL    = 3;

  localparam int M_IDLE = 0, M_HOLD = 1, M_SHL = 2, M_SHR = 3, M_TOG = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] SW = 4'b0000;
  logic       auto_en = 1'b0;
  logic [7:0] LED;
  logic [2:0] mode;
  logic       tick;

  always #5 clk = ~clk;

  led_pattern_sched #(
    .TICK_DIV(TICK_DIV),
    .DEB_CYC (DEB_CYC),
    .TOG_HALF(TOG_HALF),
    .DWELL   (DWELL)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .SW     (SW),
    .auto_en(auto_en),
    .LED    (LED),
    .mode   (mode),
    .tick   (tick)
  );

  typedef struct {
    int n;
    int led;
    int md;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  int hist[$];
  int m_n, m_st, m_led, m_tog, m_dwell;

  // Debounced value: value of the latest run of DEB_CYC equal raw samples
  // that ends at or before index 'last' (0 if none).
  function automatic int db_at(input int last);
    for (int j = last; j >= 0; j--) begin
      bit ok = 1'b1;
      for (int k = 0; k < DEB_CYC; k++) begin
        int v = (j - k >= 0) ? hist[j-k] : 0;
        if (v != hist[j]) ok = 1'b0;
      end
      if (ok) return hist[j];
    end
    return 0;
  endfunction

  function automatic int req_of(input int sw);
    if (sw & 8) return M_TOG;
    if (sw & 4) return M_SHR;
    if (sw & 2) return M_SHL;
    if (sw & 1) return M_HOLD;
    return M_IDLE;
  endfunction

  task automatic m_enter(input int s);
    m_st    = s;
    m_led   = (s == M_IDLE) ? 'h00 : (s == M_SHR) ? 'h80 : (s == M_TOG) ? 'h55 : 'h01;
    m_tog   = 0;
    m_dwell = 0;
  endtask

  task automatic m_animate();
    if (m_st == M_SHL) m_led = (m_led == 'h80) ? 'h01 : (m_led * 2);
    else if (m_st == M_SHR) m_led = (m_led == 'h01) ? 'h80 : (m_led / 2);
    else if (m_st == M_TOG) begin
      m_tog = (m_tog + 1) % (2 * TOG_HALF);
      m_led = (m_tog < TOG_HALF) ? 'h55 : 'hAA;
    end
  endtask

  initial begin
    int nxt[5];
    nxt = '{M_HOLD, M_SHL, M_SHR, M_TOG, M_HOLD};
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_n = 0; m_st = M_IDLE; m_led = 0; m_tog = 0; m_dwell = 0;
        hist.delete();
      end else begin
        hist.push_back(int'(SW));
        if (m_n % TICK_DIV == TICK_DIV - 1) begin
          int rq;
          exp_t e;
          rq = req_of(db_at(m_n - 3));
          if (!auto_en) begin
            if (rq != m_st) m_enter(rq);
            else m_animate();
          end else if (m_st == M_IDLE) m_enter(M_HOLD);
          else if (m_dwell == DWELL - 1) m_enter(nxt[m_st]);
          else begin
            m_animate();
            m_dwell++;
          end
          e.n = m_n; e.led = m_led; e.md = m_st;
          sb_q.push_back(e);
        end
        m_n++;
      end
    end
  end

  // ---------------- monitor ----------------
  int mon_n = 0;

  initial begin
    logic t;
    exp_t e;
    forever begin
      @(negedge clk);
      t = tick;
      @(posedge clk);
      if (!rst_n) begin
        mon_n = 0;
      end else begin
        #1;
        if (t) begin
          if (sb_q.size() == 0) begin
            check("unexpected_tick", mon_n, -1);
          end else begin
            e = sb_q.pop_front();
            $display("tick edge=%0d LED=%02h mode=%0d exp_LED=%02h exp_mode=%0d",
                     mon_n, LED, mode, e.led, e.md);
            check("tick_edge", mon_n, e.n);
            check("led", int'(LED), e.led);
            check("mode", int'(mode), e.md);
          end
        end
        mon_n++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0] keep;
    rst_n = 1'b0; SW = 4'b0000; auto_en = 1'b0;
    wait_cyc(3);
    check("reset_led", int'(LED), 0);
    check("reset_mode", int'(mode), M_IDLE);
    check("reset_tick", int'(tick), 0);
    rst_n = 1'b1;

    SW = 4'b0010; wait_cyc(TICK_DIV * 12);
    SW = 4'b0100; wait_cyc(TICK_DIV * 12);
    SW = 4'b1001; wait_cyc(TICK_DIV * 8);
    SW = 4'b0000; wait_cyc(TICK_DIV * 4);
    SW = 4'b0001; wait_cyc(1);
    SW = 4'b0000; wait_cyc(TICK_DIV * 6);
    auto_en = 1'b1; wait_cyc(TICK_DIV * 20);
    auto_en = 1'b0; wait_cyc(TICK_DIV * 6);

    // Asynchronous reset while shifting left, asserted between clock edges.
    SW = 4'b0010; wait_cyc(TICK_DIV * 6);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", int'(LED), 0);
    check("async_rst_mode", int'(mode), M_IDLE);
    check("async_rst_tick", int'(tick), 0);
    check("sb_drained_at_reset", sb_q.size(), 0);
    sb_q.delete();
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(TICK_DIV * 8);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        SW = 4'($urandom);
      end else if (r < 5) begin
        keep = SW;
        SW = 4'($urandom);
        wait_cyc(1);
        SW = keep;
      end
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      wait_cyc(1);
    end

    wait_cyc(TICK_DIV * 3);
    check("sb_drained_at_end", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
